c2hdl_dmem: RTL and testbench
=============================

# c2hdl_dmem

Single-port data memory slave serving the generated C-to-HDL processing blocks' load/store bus (`addr`, `size`, `valid`, `write`, `wdata`, `rdata`, `ready`). It sits directly downstream of a generated function block and answers every stack spill/fill and array access with a one-cycle `ready` pulse after a programmable number of wait states. Byte, halfword and word lanes are supported, little-endian, with right-justified read data.

## Interface
- `AW`, default 8: word-index width; memory depth 2^AW words of 32 bits (default 1 KiB).
- `WAIT`, default 1: wait states inserted between request acceptance and `ready`; 0..15.
- `clk` in 1: clock, rising edge.
- `rstb` in 1: reset. One clock; reset is asynchronous and active-low.
- `valid` in 1: request present; held by master until `ready` seen.
- `write` in 1: 1 = store, 0 = load; stable while `valid`.
- `size` in 3: 0 byte, 1 halfword, 2 word; values 3..7 treated as word.
- `addr` in 32: byte address; bits [AW+1:2] select word, [1:0] select lane, upper bits ignored (wrap).
- `wdata` in 32: store data, right-justified (byte in [7:0], half in [15:0]).
- `rdata` out 32: load data, right-justified, upper bits zero.
- `ready` out 1: one-cycle completion pulse.
- `busy` out 1: high from acceptance through the `ready` cycle.
- `err` out 1: sticky misalignment flag (only with `DMEM_MISALIGN_ERR_EN`).

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: `valid`=1 → latch `addr`, `size`, `write`, `wdata`; go WAIT if `WAIT`>0 (counter loaded with `WAIT`-1), else RESP.
- WAIT: counter decrements each cycle; at 0 → RESP. `valid` dropped → IDLE, no write, no `ready`.
- RESP: `ready`=1 for exactly one cycle; next state IDLE unconditionally. A `valid` still high in the cycle after RESP is not a new request; a new request is accepted only after `valid` has been sampled low once.
- Store: memory written on the clock edge entering RESP. Byte: lane `addr[1:0]` ← `wdata[7:0]`. Half: lanes {addr[1],0}+0/1 ← `wdata[15:0]`. Word: all four lanes. Unwritten lanes unchanged.
- Load: word read on the edge entering RESP; `rdata` = word >> (8×lane offset), masked to 8/16/32 bits by `size`. Master performs any sign extension.
- Misalignment (half with `addr[0]`=1, word with `addr[1:0]`≠0): access served with offending low bits cleared.
- `rdata` holds its value until the next load response; stores leave `rdata` unchanged.

## Timing
- Reset values: `ready`=0, `busy`=0, `rdata`=0, `err`=0, state IDLE, counter 0. Memory array not reset.
- `valid` first sampled high at edge t → `ready` high during cycle t+1+`WAIT`; `rdata` valid in that same cycle.
- Back-to-back: master drops `valid` at the `ready` edge and may re-raise it one cycle later; minimum request-to-request spacing = `WAIT`+3 cycles.
- `rstb` low mid-transaction: immediate return to IDLE, pending store discarded, `ready` cleared.
- All outputs registered; no combinational path from `valid` to `ready`.

## Configuration
- `DMEM_MISALIGN_ERR_EN` defined: `err` port present; set on the edge entering RESP for any misaligned access, cleared only by `rstb`; access still served aligned.
- Undefined: `err` port and its logic absent; misaligned accesses silently aligned.

## Test plan
- Reset: hold `rstb`=0 with `valid`=1 → `ready`=0, `busy`=0, `rdata`=0; after release, first request completes normally.
- Word store then load, `WAIT`=1: sw 0xDEADBEEF @0x10, lw @0x10 → `ready` 2 cycles after `valid` sampled, `rdata`=0xDEADBEEF.
- Byte/half lanes: sw 0x11223344 @0x20; sb 0xAA @0x21; lb @0x21 → 0x000000AA; lh @0x22 → 0x00001122; lw @0x20 → 0x1122AA44.
- Wait-state sweep `WAIT`=0,3,15: request-to-`ready` latency = `WAIT`+1 cycles; `ready` exactly one cycle wide every time.
- Abort/reset: drop `valid` during WAIT on a store, and separately pull `rstb` low mid-WAIT → no `ready`, target word unchanged on readback.
- With `DMEM_MISALIGN_ERR_EN`: lw @0x13 → served as @0x10, `err`=1 and stays 1 across later aligned accesses until reset; address 0x400+0x10 with `AW`=8 aliases 0x10.

Source files
------------

// File: rtl/c2hdl_dmem_if.sv
// rtl/c2hdl_dmem_if.sv - load/store bus between a generated function block and c2hdl_dmem
// Signals:
//   valid  request present, held until ready
//   write  1 = store, 0 = load
//   size   0 byte, 1 halfword, 2..7 word
//   addr   byte address
//   wdata  store data, right-justified
//   rdata  load data, right-justified, upper bits zero
//   ready  one-cycle completion pulse
//   busy   high from acceptance through the ready cycle
interface c2hdl_dmem_if;
    logic        valid;
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;

    modport master (
        output valid, write, size, addr, wdata,
        input  rdata, ready, busy
    );

    modport slave (
        input  valid, write, size, addr, wdata,
        output rdata, ready, busy
    );
endinterface

// File: rtl/c2hdl_dmem.sv
// rtl/c2hdl_dmem.sv - single-port 32-bit data memory slave with programmable wait states
// Parameters:
//   AW    word-index width, depth 2^AW words
//   WAIT  wait states between acceptance and ready (0..15)
// Ports:
//   i_clk   clock, rising edge
//   i_rstb  asynchronous active-low reset
//   bus     c2hdl_dmem_if slave modport (valid/write/size/addr/wdata in, rdata/ready/busy out)
//   o_err   sticky misalignment flag, present only when DMEM_MISALIGN_ERR_EN is defined
// Optional feature macro: DMEM_MISALIGN_ERR_EN
module c2hdl_dmem #(
    parameter int AW   = 8,
    parameter int WAIT = 1
) (
    input  logic          i_clk,
    input  logic          i_rstb,
    c2hdl_dmem_if.slave   bus
`ifdef DMEM_MISALIGN_ERR_EN
    ,
    output logic          o_err
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    localparam logic [3:0] LP_CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    state_t        r_state, w_next;
    logic [3:0]    r_cnt, w_cnt_next;
    logic          w_accept;
    logic          r_need_low;

    logic [AW+1:0] r_addr;
    logic [2:0]    r_size;
    logic          r_write;
    logic [31:0]   r_wdata;

    logic          r_ready;
    logic          r_busy;
    logic [31:0]   r_rdata;

    logic [31:0]   r_mem [2**AW];

    logic [AW+1:0] w_req_addr;
    logic [2:0]    w_req_size;
    logic          w_req_write;
    logic [31:0]   w_req_wdata;
    logic          w_is_byte, w_is_half;
    logic [1:0]    w_lane;
    logic          w_misalign;
    logic [AW-1:0] w_word;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata_sh;
    logic [31:0]   w_rd_sh;
    logic [31:0]   w_rd_val;
    logic          w_enter_resp;
    logic          w_unused;

    assign w_unused = ^bus.addr[31:AW+2];

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_accept   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A valid left high after a response must be seen low once before it counts again
                if (bus.valid && !r_need_low) begin
                    w_accept = 1'b1;
                    if (WAIT == 0) begin
                        w_next = ST_RESP;
                    end else begin
                        w_next     = ST_WAIT;
                        w_cnt_next = LP_CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!bus.valid) begin
                    w_next = ST_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_next = ST_RESP;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // With WAIT=0 the response is entered on the acceptance edge, so the live bus is used there
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_req_addr  = bus.addr[AW+1:0];
            w_req_size  = bus.size;
            w_req_write = bus.write;
            w_req_wdata = bus.wdata;
        end else begin
            w_req_addr  = r_addr;
            w_req_size  = r_size;
            w_req_write = r_write;
            w_req_wdata = r_wdata;
        end
    end

    assign w_is_byte  = (w_req_size == 3'd0);
    assign w_is_half  = (w_req_size == 3'd1);
    assign w_lane     = w_is_byte ? w_req_addr[1:0] :
                        w_is_half ? {w_req_addr[1], 1'b0} : 2'b00;
    assign w_misalign = (w_is_half && w_req_addr[0]) ||
                        (!w_is_byte && !w_is_half && (w_req_addr[1:0] != 2'b00));
    assign w_word     = w_req_addr[AW+1:2];
    assign w_be       = w_is_byte ? (4'b0001 << w_lane) :
                        w_is_half ? (4'b0011 << w_lane) : 4'b1111;
    assign w_wdata_sh = w_req_wdata << {w_lane, 3'b000};
    assign w_rd_sh    = r_mem[w_word] >> {w_lane, 3'b000};
    assign w_rd_val   = w_is_byte ? {24'd0, w_rd_sh[7:0]} :
                        w_is_half ? {16'd0, w_rd_sh[15:0]} : w_rd_sh;

    assign w_enter_resp = (w_next == ST_RESP);

    // Gated by reset so a store racing an asserted reset is discarded
    always_ff @(posedge i_clk) begin
        if (i_rstb && w_enter_resp && w_req_write) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_word][8*i +: 8] <= w_wdata_sh[8*i +: 8];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_need_low <= 1'b0;
            r_addr     <= '0;
            r_size     <= 3'd0;
            r_write    <= 1'b0;
            r_wdata    <= 32'd0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_rdata    <= 32'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_ready <= (w_next == ST_RESP);
            r_busy  <= (w_next != ST_IDLE);
            if (w_accept) begin
                r_addr  <= bus.addr[AW+1:0];
                r_size  <= bus.size;
                r_write <= bus.write;
                r_wdata <= bus.wdata;
            end
            if (w_enter_resp && !w_req_write) r_rdata <= w_rd_val;
            if (r_state == ST_RESP) begin
                r_need_low <= 1'b1;
            end else if (r_state == ST_IDLE && !bus.valid) begin
                r_need_low <= 1'b0;
            end
        end
    end

    assign bus.ready = r_ready;
    assign bus.busy  = r_busy;
    assign bus.rdata = r_rdata;

`ifdef DMEM_MISALIGN_ERR_EN
    logic r_err;
    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            r_err <= 1'b0;
        end else if (w_enter_resp && w_misalign) begin
            r_err <= 1'b1;
        end
    end
    assign o_err = r_err;
`else
    logic w_unused_misalign;
    assign w_unused_misalign = w_misalign;
`endif

endmodule

// File: tb/tb_c2hdl_dmem.sv
// tb/tb_c2hdl_dmem.sv - self-checking bench for c2hdl_dmem
module tb_c2hdl_dmem;
    localparam int AW = 8;
    localparam int NB = 4 * (2 ** AW);

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_write = 1'b0;
    logic [2:0]  m_size = 3'd0;
    logic [31:0] m_addr = 32'd0;
    logic [31:0] m_wdata = 32'd0;

    always #5 clk = ~clk;

    c2hdl_dmem_if if0 ();
    c2hdl_dmem_if if1 ();
    c2hdl_dmem_if if3 ();
    c2hdl_dmem_if if15 ();

    assign if0.valid  = m_valid;  assign if0.write  = m_write;  assign if0.size  = m_size;
    assign if0.addr   = m_addr;   assign if0.wdata  = m_wdata;
    assign if1.valid  = m_valid;  assign if1.write  = m_write;  assign if1.size  = m_size;
    assign if1.addr   = m_addr;   assign if1.wdata  = m_wdata;
    assign if3.valid  = m_valid;  assign if3.write  = m_write;  assign if3.size  = m_size;
    assign if3.addr   = m_addr;   assign if3.wdata  = m_wdata;
    assign if15.valid = m_valid;  assign if15.write = m_write;  assign if15.size = m_size;
    assign if15.addr  = m_addr;   assign if15.wdata = m_wdata;

`ifdef DMEM_MISALIGN_ERR_EN
    logic err0, err1, err3, err15;
`endif

    c2hdl_dmem #(.AW(AW), .WAIT(0)) u0 (.i_clk(clk), .i_rstb(rstb), .bus(if0)
`ifdef DMEM_MISALIGN_ERR_EN
        , .o_err(err0)
`endif
    );
    c2hdl_dmem #(.AW(AW), .WAIT(1)) u1 (.i_clk(clk), .i_rstb(rstb), .bus(if1)
`ifdef DMEM_MISALIGN_ERR_EN
        , .o_err(err1)
`endif
    );
    c2hdl_dmem #(.AW(AW), .WAIT(3)) u3 (.i_clk(clk), .i_rstb(rstb), .bus(if3)
`ifdef DMEM_MISALIGN_ERR_EN
        , .o_err(err3)
`endif
    );
    c2hdl_dmem #(.AW(AW), .WAIT(15)) u15 (.i_clk(clk), .i_rstb(rstb), .bus(if15)
`ifdef DMEM_MISALIGN_ERR_EN
        , .o_err(err15)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Byte-addressed reference memory for the WAIT=1 instance
    logic [7:0]  mdl [NB];
    logic [31:0] last_load = 32'd0;
    logic        exp_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] sz);
        return (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : 4;
    endfunction

    function automatic int base_idx(input logic [31:0] a, input logic [2:0] sz);
        int n = nbytes(sz);
        return (int'(a % NB) / n) * n;
    endfunction

    function automatic bit is_misaligned(input logic [31:0] a, input logic [2:0] sz);
        return (a % nbytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] mdl_load(input logic [2:0] sz, input logic [31:0] a);
        logic [31:0] r = 32'd0;
        int b = base_idx(a, sz);
        for (int i = 0; i < nbytes(sz); i++) r[8*i +: 8] = mdl[b + i];
        return r;
    endfunction

    task automatic mdl_store(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int b = base_idx(a, sz);
        for (int i = 0; i < nbytes(sz); i++) mdl[b + i] = wd[8*i +: 8];
    endtask

    // One full request on the shared bus, timed and checked against the WAIT=1 instance
    task automatic req(input bit w, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd);
        int lat = 0;
        bit got = 0;
        @(negedge clk);
        m_valid = 1'b1; m_write = w; m_size = sz; m_addr = a; m_wdata = wd;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (if1.ready) got = 1;
        end
        rd = if1.rdata;
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL req_timeout: got no ready after %0d cycles, required ready", lat);
        end else begin
            check("latency", lat, 2);
            if (is_misaligned(a, sz)) exp_err = 1'b1;
`ifdef DMEM_MISALIGN_ERR_EN
            check("err", {31'd0, err1}, {31'd0, exp_err});
`endif
            if (w) begin
                mdl_store(sz, a, wd);
                check("rdata_hold", rd, last_load);
            end else begin
                last_load = mdl_load(sz, a);
                check("load", rd, last_load);
            end
        end
        m_valid = 1'b0;
        @(negedge clk);
        check("ready_width", {31'd0, if1.ready}, 32'd0);
    endtask

    typedef struct {
        bit          w;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[9];
    logic [31:0] rd;

    initial begin
        tbl[0] = '{1'b1, 3'd2, 32'h0000_0010, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{1'b0, 3'd2, 32'h0000_0010, 32'h0,        32'hDEADBEEF};
        tbl[2] = '{1'b1, 3'd2, 32'h0000_0020, 32'h11223344, 32'h0};
        tbl[3] = '{1'b1, 3'd0, 32'h0000_0021, 32'h000000AA, 32'h0};
        tbl[4] = '{1'b0, 3'd0, 32'h0000_0021, 32'h0,        32'h000000AA};
        tbl[5] = '{1'b0, 3'd1, 32'h0000_0022, 32'h0,        32'h00001122};
        tbl[6] = '{1'b0, 3'd2, 32'h0000_0020, 32'h0,        32'h1122AA44};
        tbl[7] = '{1'b1, 3'd2, 32'h0000_0410, 32'h55667788, 32'h0};
        tbl[8] = '{1'b0, 3'd2, 32'h0000_0010, 32'h0,        32'h55667788};

        // Reset held with a request pending
        m_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, if1.ready}, 32'd0);
        check("rst_busy",  {31'd0, if1.busy},  32'd0);
        check("rst_rdata", if1.rdata, 32'd0);
`ifdef DMEM_MISALIGN_ERR_EN
        check("rst_err", {31'd0, err1}, 32'd0);
`endif
        m_valid = 1'b0;
        rstb = 1'b1;

        for (int i = 0; i < 9; i++) begin
            req(tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].wd, rd);
            if (!tbl[i].w) check($sformatf("vec%0d", i), rd, tbl[i].exp);
        end

        // Latency sweep; valid stays high well past each response
        begin
            int first[4];
            int cnt[4];
            logic [3:0] rdy;
            for (int k = 0; k < 4; k++) begin first[k] = -1; cnt[k] = 0; end
            @(negedge clk);
            m_valid = 1'b1; m_write = 1'b0; m_size = 3'd2; m_addr = 32'h10;
            for (int c = 1; c <= 24; c++) begin
                @(negedge clk);
                rdy = {if15.ready, if3.ready, if1.ready, if0.ready};
                for (int k = 0; k < 4; k++) begin
                    if (rdy[k]) begin
                        cnt[k]++;
                        if (first[k] < 0) first[k] = c;
                    end
                end
            end
            m_valid = 1'b0;
            @(negedge clk);
            check("sweep_lat_w0",  first[0], 1);
            check("sweep_lat_w1",  first[1], 2);
            check("sweep_lat_w3",  first[2], 4);
            check("sweep_lat_w15", first[3], 16);
            check("sweep_cnt_w0",  cnt[0], 1);
            check("sweep_cnt_w1",  cnt[1], 1);
            check("sweep_cnt_w3",  cnt[2], 1);
            check("sweep_cnt_w15", cnt[3], 1);
            last_load = mdl_load(3'd2, 32'h10);
            check("sweep_rdata", if1.rdata, last_load);
        end

        // Store aborted by dropping valid during WAIT
        req(1'b1, 3'd2, 32'h30, 32'h12345678, rd);
        begin
            int seen = 0;
            @(negedge clk);
            m_valid = 1'b1; m_write = 1'b1; m_size = 3'd2; m_addr = 32'h30; m_wdata = 32'hCAFEF00D;
            @(negedge clk);
            check("abort_busy", {31'd0, if1.busy}, 32'd1);
            m_valid = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (if1.ready) seen++;
            end
            check("abort_no_ready", seen, 0);
        end
        req(1'b0, 3'd2, 32'h30, 32'h0, rd);

        // Reset pulled low mid-WAIT on a store
        @(negedge clk);
        m_valid = 1'b1; m_write = 1'b1; m_size = 3'd2; m_addr = 32'h30; m_wdata = 32'h0BADF00D;
        @(negedge clk);
        rstb = 1'b0;
        @(negedge clk);
        check("midrst_ready", {31'd0, if1.ready}, 32'd0);
        check("midrst_busy",  {31'd0, if1.busy},  32'd0);
        check("midrst_rdata", if1.rdata, 32'd0);
        m_valid = 1'b0;
        rstb = 1'b1;
        last_load = 32'd0;
        exp_err = 1'b0;
        req(1'b0, 3'd2, 32'h30, 32'h0, rd);

        // Misaligned word load is served aligned; err stays set afterwards
        req(1'b0, 3'd2, 32'h13, 32'h0, rd);
        req(1'b0, 3'd1, 32'h23, 32'h0, rd);
        req(1'b0, 3'd2, 32'h20, 32'h0, rd);

        // Randomised traffic over a small window with ignored upper address bits
        for (int i = 0; i < 16; i++) req(1'b1, 3'd2, 32'(i * 4), $urandom, rd);
        for (int i = 0; i < 150; i++) begin
            req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                $urandom & 32'hFFFF_F03F, $urandom, rd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end
endmodule
